gray_cnt: RTL

Parameterized N-bit Gray-code counter. It is the upstream producer for the gray-to-binary converter stage. Gray output comes straight from a flop, so it is glitch-free and safe to hand across a clock-domain boundary as a pointer. A binary shadow register is kept internally and exposed for same-domain users.

---
 rtl/gray_pkg.sv | 42 ++++
 rtl/gray_cnt_bin2gray.sv | 16 +
 rtl/gray_cnt.sv | 118 +++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code counter and its converter stages.
// Functions work on a wide word; callers zero-extend and truncate to their own width.
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_STEP,
        OP_SAT
    } cnt_op_e;

    function automatic gray_word_t bin2gray(input gray_word_t x);
        return x ^ (x >> 1);
    endfunction

    // Inverse mapping, shared with the downstream gray-to-binary stage.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = g;
        for (int s = 1; s < GRAY_MAX_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

    function automatic gray_word_t cnt_max(input int n);
        if (n >= GRAY_MAX_W) begin
            return '1;
        end
        return (gray_word_t'(1) << n) - gray_word_t'(1);
    endfunction

    function automatic logic is_hamming1(input gray_word_t a, input gray_word_t b);
        return ($countones(a ^ b) == 1);
    endfunction

endpackage

// File: rtl/gray_cnt_bin2gray.sv
// Combinational binary-to-Gray encoder; the mirror of the downstream gray-to-binary converter.
module bin2gray_N
    import gray_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_bin,
    output logic [N-1:0] o_gray
);

    gray_word_t w_wide;

    assign w_wide = bin2gray(GRAY_MAX_W'(i_bin));
    assign o_gray = w_wide[N-1:0];

endmodule

// File: rtl/gray_cnt.sv
// N-bit up/down Gray-code counter with a binary shadow and optional wrap/saturate.
// Optional macro GRAY_CNT_CHECK_EN adds a sticky err output flagging non-single-bit steps.
module gray_cnt
    import gray_pkg::*;
#(
    parameter int N    = 4,
    parameter bit WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_bin,
    input  logic         en,
    input  logic         up,
    output logic [N-1:0] gray,
    output logic [N-1:0] bin,
    output logic         tc,
`ifdef GRAY_CNT_CHECK_EN
    output logic         err,
`endif
    output logic         wrap
);

    localparam gray_word_t CNT_MAX_W = cnt_max(N);
    localparam logic [N-1:0] CNT_MAX = CNT_MAX_W[N-1:0];

    logic [N-1:0] r_bin;
    logic [N-1:0] r_gray;
    logic         r_wrap;

    logic         w_tc;
    cnt_op_e      w_op;
    logic [N-1:0] w_nextBin;
    logic [N-1:0] w_nextGray;
    logic         w_nextWrap;

    assign w_tc = up ? (r_bin == CNT_MAX) : (r_bin == '0);

    // Priority decode; a terminal-count step either wraps or saturates depending on WRAP.
    always_comb begin
        w_op = OP_HOLD;
        if (clr) begin
            w_op = OP_CLR;
        end else if (load) begin
            w_op = OP_LOAD;
        end else if (en) begin
            if (w_tc && !WRAP) begin
                w_op = OP_SAT;
            end else begin
                w_op = OP_STEP;
            end
        end
    end

    always_comb begin
        w_nextBin  = r_bin;
        w_nextWrap = 1'b0;
        case (w_op)
            OP_CLR:  w_nextBin = '0;
            OP_LOAD: w_nextBin = load_bin;
            OP_STEP: begin
                w_nextBin  = up ? (r_bin + N'(1)) : (r_bin - N'(1));
                w_nextWrap = w_tc;
            end
            default: w_nextBin = r_bin;
        endcase
    end

    bin2gray_N #(
        .N (N)
    ) u_bin2gray (
        .i_bin  (w_nextBin),
        .o_gray (w_nextGray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_nextBin;
            r_gray <= w_nextGray;
            r_wrap <= w_nextWrap;
        end
    end

    assign gray = r_gray;
    assign bin  = r_bin;
    assign tc   = w_tc;
    assign wrap = r_wrap;

`ifdef GRAY_CNT_CHECK_EN
    logic [N-1:0] r_prevGray;
    logic         r_stepDone;
    logic         r_err;

    // Compare the gray flop against its previous value one cycle after a real step,
    // so a fault in the flop itself is caught, not just in the encoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prevGray <= '0;
            r_stepDone <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_prevGray <= r_gray;
            r_stepDone <= (w_op == OP_STEP);
            if (r_stepDone && !is_hamming1(GRAY_MAX_W'(r_prevGray), GRAY_MAX_W'(r_gray))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

endmodule
